freq_bcd_conv: RTL and testbench

FREQ_BCD_CONV -- requirements
Module: freq_bcd_conv

---
 rtl/freq_bcd_conv.sv | 172 +++++++++++++++++
 tb/tb_freq_bcd_conv.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_bcd_conv.sv
// ---------------------------------------------------------------------------
// freq_bcd_conv
// Converts a 32-bit unsigned binary frequency (Hz) into ten packed BCD digits
// using sequential double-dabble, one shift per clock. The displayed result
// (bcd_o / digit_cnt_o) is held stable for the whole conversion and only
// updates on the finishing edge, so a display can read it at any time.
//
// Ports
//    clk_i        : clock, all state changes on its rising edge
//    rst_i        : synchronous active-high reset
//    freq_i[31:0] : binary frequency to convert
//    start_i      : single-cycle conversion request
//    bcd_o[39:0]  : ten BCD digits, [3:0] units ... [39:36] 10^9
//    digit_cnt_o  : number of significant digits (1..10)
//    busy_o       : high while a conversion is running
//    done_o       : one-cycle pulse when bcd_o / digit_cnt_o update
// ---------------------------------------------------------------------------
module freq_bcd_conv (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] freq_i,
   input  logic        start_i,
   output logic [39:0] bcd_o,
   output logic [3:0]  digit_cnt_o,
   output logic        busy_o,
   output logic        done_o
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      r_state;
   logic [31:0] r_bin;
   logic [39:0] r_scratch;
   logic [4:0]  r_count;
   logic [39:0] r_bcd;
   logic [3:0]  r_digit_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_pend;
   logic [31:0] r_pend_val;

   state_t      w_state_nxt;
   logic [31:0] w_bin_nxt;
   logic [39:0] w_scratch_nxt;
   logic [4:0]  w_count_nxt;
   logic [39:0] w_bcd_nxt;
   logic [3:0]  w_digit_cnt_nxt;
   logic        w_busy_nxt;
   logic        w_done_nxt;
   logic        w_pend_nxt;
   logic [31:0] w_pend_val_nxt;

   logic [39:0] w_adj;
   logic [3:0]  w_digits;

   // Double-dabble correction: every scratch digit of 5 or more gets +3 so
   // that the following left shift carries correctly into the next digit.
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < 10; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
   end

   // Significant digit count: position of the highest nonzero digit plus one,
   // falling back to 1 so that a zero result still shows a single "0".
   always_comb begin
      w_digits = 4'd1;
      for (int i = 0; i < 10; i++) begin
         if (r_scratch[4*i +: 4] != 4'd0)
            w_digits = 4'(i + 1);
      end
   end

   // Next-state and output logic. Everything holds by default; done is a
   // pulse so it defaults low. A start while busy is parked in the pending
   // register (latest request wins) and picked up at the DONE edge, where a
   // start arriving on that very edge takes priority over the parked value.
   always_comb begin
      w_state_nxt     = r_state;
      w_bin_nxt       = r_bin;
      w_scratch_nxt   = r_scratch;
      w_count_nxt     = r_count;
      w_bcd_nxt       = r_bcd;
      w_digit_cnt_nxt = r_digit_cnt;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_pend_nxt      = r_pend;
      w_pend_val_nxt  = r_pend_val;

      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_bin_nxt     = freq_i;
               w_scratch_nxt = 40'd0;
               w_count_nxt   = 5'd0;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = SHIFT;
            end
         end

         SHIFT: begin
            w_scratch_nxt = {w_adj[38:0], r_bin[31]};
            w_bin_nxt     = {r_bin[30:0], 1'b0};
            w_count_nxt   = r_count + 5'd1;
            if (r_count == 5'd31)
               w_state_nxt = DONE;
            if (start_i) begin
               w_pend_nxt     = 1'b1;
               w_pend_val_nxt = freq_i;
            end
         end

         DONE: begin
            w_bcd_nxt       = r_scratch;
            w_digit_cnt_nxt = w_digits;
            w_done_nxt      = 1'b1;
            if (start_i || r_pend) begin
               w_bin_nxt     = start_i ? freq_i : r_pend_val;
               w_scratch_nxt = 40'd0;
               w_count_nxt   = 5'd0;
               w_pend_nxt    = 1'b0;
               w_busy_nxt    = 1'b1;
               w_state_nxt   = SHIFT;
            end else begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State register. Reset wins over everything, including a start on the
   // same edge, and aborts any conversion in flight without a done pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_bin       <= 32'd0;
         r_scratch   <= 40'd0;
         r_count     <= 5'd0;
         r_bcd       <= 40'd0;
         r_digit_cnt <= 4'd1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pend      <= 1'b0;
         r_pend_val  <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_bin       <= w_bin_nxt;
         r_scratch   <= w_scratch_nxt;
         r_count     <= w_count_nxt;
         r_bcd       <= w_bcd_nxt;
         r_digit_cnt <= w_digit_cnt_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_pend      <= w_pend_nxt;
         r_pend_val  <= w_pend_val_nxt;
      end
   end

   assign bcd_o       = r_bcd;
   assign digit_cnt_o = r_digit_cnt;
   assign busy_o      = r_busy;
   assign done_o      = r_done;

endmodule

// File: tb/tb_freq_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_freq_bcd_conv
// Self-checking bench for freq_bcd_conv. Directed steps drive conversions;
// each request pushes its expected BCD result (from a divide-by-ten model)
// onto a scoreboard queue, and a monitor pops and compares on every done_o.
// ---------------------------------------------------------------------------
module tb_freq_bcd_conv;

   logic        clk;
   logic        rst;
   logic [31:0] freq;
   logic        start;
   logic [39:0] bcd;
   logic [3:0]  digitCnt;
   logic        busy;
   logic        done;

   typedef struct {
      logic [39:0] bcd;
      logic [3:0]  cnt;
   } expT;

   expT expQ[$];
   int  checks     = 0;
   int  errors     = 0;
   int  donePulses = 0;

   freq_bcd_conv dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .freq_i      (freq),
      .start_i     (start),
      .bcd_o       (bcd),
      .digit_cnt_o (digitCnt),
      .busy_o      (busy),
      .done_o      (done)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: repeated division by ten, independent of double-dabble.
   function automatic expT modelConvert(input logic [31:0] v);
      expT         r;
      logic [31:0] t;
      t     = v;
      r.bcd = 40'd0;
      r.cnt = 4'd1;
      for (int i = 0; i < 10; i++) begin
         r.bcd[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      for (int i = 0; i < 10; i++) begin
         if (r.bcd[4*i +: 4] != 4'd0)
            r.cnt = 4'(i + 1);
      end
      return r;
   endfunction

   // One comparison: counts it and reports any difference.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic stepCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Pulse start for one edge; the request is sampled on the edge this task
   // steps over. overwrite replaces a still-pending expectation (latest wins).
   task automatic applyStimulus(input logic [31:0] value, input bit overwrite);
      if (overwrite && expQ.size() > 0) void'(expQ.pop_back());
      expQ.push_back(modelConvert(value));
      freq  = value;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
   endtask

   // Full single conversion from an idle block: latency, busy width and
   // display stability while the conversion runs.
   task automatic convertAndCheck(input logic [31:0] value, input logic [39:0] prevBcd,
                                  input string tag);
      int busyCycles;
      applyStimulus(value, 1'b0);
      busyCycles = (busy === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 32; i++) begin
         stepCycle();
         if (busy === 1'b1) busyCycles++;
      end
      checkOutput({tag, " done low before finish"}, {63'd0, done}, 64'd0);
      checkOutput({tag, " bcd held during conversion"}, {24'd0, bcd}, {24'd0, prevBcd});
      stepCycle();
      if (busy === 1'b1) busyCycles++;
      checkOutput({tag, " done at k+33"}, {63'd0, done}, 64'd1);
      checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'd33);
      stepCycle();
      checkOutput({tag, " done single pulse"}, {63'd0, done}, 64'd0);
   endtask

   // Scoreboard monitor: sampled mid-cycle, compares each done pulse against
   // the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         expT e;
         donePulses++;
         checkOutput("result expected at done", 64'(expQ.size() > 0), 64'd1);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("bcd_o at done", {24'd0, bcd}, {24'd0, e.bcd});
            checkOutput("digit_cnt_o at done", {60'd0, digitCnt}, {60'd0, e.cnt});
         end
      end
   end

   initial begin
      int pulsesBefore;
      rst   = 1'b1;
      start = 1'b0;
      freq  = 32'd0;
      stepCycles(2);

      // Reset state
      checkOutput("reset bcd", {24'd0, bcd}, 64'd0);
      checkOutput("reset digit_cnt", {60'd0, digitCnt}, 64'd1);
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset done", {63'd0, done}, 64'd0);
      rst = 1'b0;
      stepCycle();

      // Zero, 1000, maximum value, and a nine-digit value
      convertAndCheck(32'd0, 40'h0, "zero");
      convertAndCheck(32'd1000, 40'h0, "1000");
      convertAndCheck(32'd4294967295, 40'h0000001000, "max");
      convertAndCheck(32'd100000000, 40'h4294967295, "1e8");

      // Restart while shifting: 50 then 70 then 12345 (12345 supersedes 70)
      pulsesBefore = donePulses;
      applyStimulus(32'd50, 1'b0);
      stepCycles(5);
      applyStimulus(32'd70, 1'b0);
      stepCycles(5);
      applyStimulus(32'd12345, 1'b1);
      stepCycles(21);
      checkOutput("pending first done", {63'd0, done}, 64'd1);
      checkOutput("pending busy stays high", {63'd0, busy}, 64'd1);
      stepCycles(33);
      checkOutput("pending second done", {63'd0, done}, 64'd1);
      checkOutput("pending busy low after", {63'd0, busy}, 64'd0);
      stepCycles(5);
      checkOutput("pending done count", 64'(donePulses - pulsesBefore), 64'd2);

      // Reset mid-conversion, with a start on the reset edge that must be ignored
      pulsesBefore = donePulses;
      applyStimulus(32'd999, 1'b0);
      stepCycles(10);
      expQ.delete();
      rst   = 1'b1;
      start = 1'b1;
      freq  = 32'd5;
      stepCycle();
      rst   = 1'b0;
      start = 1'b0;
      checkOutput("abort bcd", {24'd0, bcd}, 64'd0);
      checkOutput("abort digit_cnt", {60'd0, digitCnt}, 64'd1);
      checkOutput("abort busy", {63'd0, busy}, 64'd0);
      checkOutput("abort done", {63'd0, done}, 64'd0);

      // Input changes without start have no effect
      freq = 32'd123456;
      stepCycles(20);
      freq = 32'd777;
      stepCycles(20);
      checkOutput("no done after abort", 64'(donePulses - pulsesBefore), 64'd0);
      checkOutput("idle busy", {63'd0, busy}, 64'd0);
      checkOutput("idle bcd unchanged", {24'd0, bcd}, 64'd0);

      // Start exactly on the DONE edge: 7 finishes, 8 restarts immediately
      pulsesBefore = donePulses;
      applyStimulus(32'd7, 1'b0);
      stepCycles(32);
      applyStimulus(32'd8, 1'b0);
      checkOutput("edge restart done", {63'd0, done}, 64'd1);
      checkOutput("edge restart busy", {63'd0, busy}, 64'd1);
      stepCycles(33);
      checkOutput("edge restart second done", {63'd0, done}, 64'd1);
      checkOutput("edge restart busy low", {63'd0, busy}, 64'd0);
      stepCycles(3);
      checkOutput("edge restart done count", 64'(donePulses - pulsesBefore), 64'd2);
      checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
